seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment scan controller for N_DIG common-driven digits.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_hex_decoder.sv | 33 +++
 rtl/seg7_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the 7-segment scan controller.
// Segment vectors are packed {A,B,C,D,E,F,G}, A in the MSB, active-high.
package seg7_pkg;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h72;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h1F;
    localparam logic [6:0] SEG_C   = 7'h4E;
    localparam logic [6:0] SEG_D   = 7'h3D;
    localparam logic [6:0] SEG_E   = 7'h4F;
    localparam logic [6:0] SEG_F   = 7'h47;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to {A..G} pattern; 6, 7 and 9 drawn with tails,
// b and d lowercase.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: guard blanking, PWM brightness,
// per-digit blink and leading-zero blanking, all outputs registered.
//   state   | meaning
//   S_GUARD | all DIG low for GUARD_CYC clocks while the bus changes
//   S_ON    | 2**BR_W clocks; digit lit while on_cnt < brightness
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int GUARD_CYC = 2,
    parameter int BR_W      = 4,
    parameter int BLINK_W   = 20
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [4*N_DIG-1:0]   digits_in,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blink_en,
    input  logic                 lz_blank,
    input  logic [BR_W-1:0]      brightness,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    output logic                 E,
    output logic                 F,
    output logic                 G,
    output logic                 DP,
    output logic [N_DIG-1:0]     DIG
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int GC_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GUARD_CYC - 1);
    localparam logic [BR_W-1:0]  ON_LAST  = '1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GC_W-1:0]    gcnt_q, gcnt_d;
    logic [BR_W-1:0]    on_q, on_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [3:0]         ldig_q, ldig_d;
    logic               ldp_q, ldp_d;
    logic               lblink_q, lblink_d;
    logic               lblank_q, lblank_d;
    logic [BR_W-1:0]    lbright_q, lbright_d;
    logic [6:0]         seg_q, seg_d;
    logic               dpo_q, dpo_d;
    logic [N_DIG-1:0]   dig_q, dig_d;

    logic [N_DIG-1:0]   lz_mask;
    logic               zero_run;
    logic [6:0]         dec_seg;
    logic               lit;

    // A digit is LZ-blanked only if it and every digit above it are zero;
    // its own DP request keeps it visible so "0.5" keeps the leading 0.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            zero_run   = zero_run && (digits_in[4*k +: 4] == 4'h0);
            lz_mask[k] = lz_blank && (k != 0) && zero_run && !dp_in[k];
        end
    end

    // Slot data is captured as the slot lights so the lit phase never changes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gcnt_d    = gcnt_q;
        on_d      = on_q;
        blink_d   = blink_q + 1'b1;
        ldig_d    = ldig_q;
        ldp_d     = ldp_q;
        lblink_d  = lblink_q;
        lblank_d  = lblank_q;
        lbright_d = lbright_q;
        case (state_q)
            S_GUARD: begin
                if (gcnt_q == GC_LAST) begin
                    state_d   = S_ON;
                    gcnt_d    = '0;
                    on_d      = '0;
                    ldig_d    = digits_in[4*int'(idx_q) +: 4];
                    ldp_d     = dp_in[idx_q];
                    lblink_d  = blink_en[idx_q];
                    lblank_d  = lz_mask[idx_q];
                    lbright_d = brightness;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (on_q == ON_LAST) begin
                    state_d = S_GUARD;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    on_d = on_q + 1'b1;
                end
            end
            default: state_d = S_GUARD;
        endcase
    end

    seg7_hex_decoder u_dec (
        .hex_i (ldig_d),
        .seg_o (dec_seg)
    );

    always_comb begin
        lit   = (state_d == S_ON) && (on_d < lbright_d) &&
                !(lblink_d && blink_d[BLINK_W-1]) && !lblank_d;
        seg_d = lit ? dec_seg : SEG_OFF;
        dpo_d = lit && ldp_d;
        dig_d = lit ? (N_DIG'(1) << idx_d) : '0;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= S_GUARD;
            idx_q     <= '0;
            gcnt_q    <= '0;
            on_q      <= '0;
            blink_q   <= '0;
            ldig_q    <= '0;
            ldp_q     <= 1'b0;
            lblink_q  <= 1'b0;
            lblank_q  <= 1'b0;
            lbright_q <= '0;
            seg_q     <= SEG_OFF;
            dpo_q     <= 1'b0;
            dig_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gcnt_q    <= gcnt_d;
            on_q      <= on_d;
            blink_q   <= blink_d;
            ldig_q    <= ldig_d;
            ldp_q     <= ldp_d;
            lblink_q  <= lblink_d;
            lblank_q  <= lblank_d;
            lbright_q <= lbright_d;
            seg_q     <= seg_d;
            dpo_q     <= dpo_d;
            dig_q     <= dig_d;
        end
    end

    assign {A, B, C, D, E, F, G} = seg_q;
    assign DP  = dpo_q;
    assign DIG = dig_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus pushes the expected pins for
// every clock, a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;

    localparam int N_DIG     = 4;
    localparam int GUARD_CYC = 2;
    localparam int BR_W      = 2;
    localparam int BLINK_W   = 4;
    localparam int SLOT      = GUARD_CYC + (1 << BR_W);

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      digits_in = 16'h0;
    logic [3:0]       dp_in = 4'h0;
    logic [3:0]       blink_en = 4'h0;
    logic             lz_blank = 1'b0;
    logic [BR_W-1:0]  brightness = '0;
    logic             A, B, C, D, E, F, G, DP;
    logic [3:0]       DIG;

    seg7_scan_ctrl #(
        .N_DIG     (N_DIG),
        .GUARD_CYC (GUARD_CYC),
        .BR_W      (BR_W),
        .BLINK_W   (BLINK_W)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .A (A), .B (B), .C (C), .D (D), .E (E), .F (F), .G (G),
        .DP         (DP),
        .DIG        (DIG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        int         n;
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t  sbq[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n       = 0;
    bit    in_rst  = 1'b1;
    string cur_test = "reset";

    logic [3:0]      m_dig;
    logic            m_dp, m_ben, m_blank;
    logic [BR_W-1:0] m_bright;

    function automatic logic [6:0] hex_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110010;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Clock n after release: phase n%SLOT (0..GUARD_CYC-1 dark), digit (n/SLOT)%4,
    // blink phase = (n mod 16) >= 8; slot data captured at phase GUARD_CYC.
    task automatic step();
        exp_t e;
        int   q, idx;
        logic lit;
        @(posedge CLK);
        #1;
        e.tag = cur_test; e.dig = 4'h0; e.seg = 7'h0; e.dp = 1'b0;
        if (!in_rst) begin
            n++;
            q   = n % SLOT;
            idx = (n / SLOT) % N_DIG;
            if (q == GUARD_CYC) begin
                m_dig    = 4'((digits_in >> (4 * idx)) & 16'hF);
                m_dp     = dp_in[idx];
                m_ben    = blink_en[idx];
                m_bright = brightness;
                m_blank  = lz_blank && (idx > 0) &&
                           ((digits_in >> (4 * idx)) == 16'h0) && !dp_in[idx];
            end
            lit = (q >= GUARD_CYC) && ((q - GUARD_CYC) < int'(m_bright)) &&
                  !(m_ben && ((n % 16) >= 8)) && !m_blank;
            if (lit) begin
                e.dig = 4'(1 << idx);
                e.seg = hex_seg(m_dig);
                e.dp  = m_dp;
            end
        end
        e.n = n;
        sbq.push_back(e);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic run_to(input int slot, input int ph);
        int budget = 0;
        while (!(((n / SLOT) % N_DIG == slot) && (n % SLOT == ph)) && budget < 200) begin
            step();
            budget++;
        end
        if (budget >= 200) begin
            n_total++;
            $display("FAIL run_to(%0d,%0d): position not reached, got n=%0d", slot, ph, n);
        end
    endtask

    task automatic release_rst();
        rst = 1'b0; in_rst = 1'b0; n = 0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            n_total++;
            if ({DIG, A, B, C, D, E, F, G, DP} == {e.dig, e.seg, e.dp})
                n_pass++;
            else
                $display("FAIL %s n=%0d: got DIG=%b seg=%b DP=%b, expected DIG=%b seg=%b DP=%b",
                         e.tag, e.n, DIG, {A, B, C, D, E, F, G}, DP, e.dig, e.seg, e.dp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        run(3);
        release_rst();

        cur_test = "t1_scan_1234";
        digits_in = 16'h1234; brightness = 2'd3;
        run(2 * N_DIG * SLOT);

        cur_test = "t2_bright0";
        brightness = 2'd0;
        run(N_DIG * SLOT + SLOT);
        cur_test = "t2_bright1";
        brightness = 2'd1;
        run(N_DIG * SLOT + SLOT);

        cur_test = "t3_lz_on";
        brightness = 2'd3; digits_in = 16'h0070; lz_blank = 1'b1;
        run(N_DIG * SLOT + SLOT);
        cur_test = "t3_lz_off";
        lz_blank = 1'b0;
        run(N_DIG * SLOT + SLOT);
        cur_test = "t3_lz_dp";
        lz_blank = 1'b1; dp_in = 4'b0100;
        run(N_DIG * SLOT + SLOT);

        cur_test = "t4_blink";
        lz_blank = 1'b0; dp_in = 4'h0; digits_in = 16'h1234; blink_en = 4'b0001;
        run(3 * N_DIG * SLOT);

        cur_test = "t5_midslot";
        blink_en = 4'h0;
        run_to(1, GUARD_CYC + 1);
        digits_in = 16'h5678;
        run(N_DIG * SLOT + SLOT);

        cur_test = "t6_rst_mid";
        run_to(2, GUARD_CYC + 1);
        @(posedge CLK);
        #1;
        rst = 1'b1; in_rst = 1'b1;
        sbq.push_back('{tag: "t6_async_clear", n: n, dig: 4'h0, seg: 7'h0, dp: 1'b0});
        run(2);
        release_rst();
        cur_test = "t6_resume";
        run(N_DIG * SLOT + SLOT);

        @(negedge CLK);
        @(negedge CLK);
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
